// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches device IRQ rising edges, masks them, and presents one
// winner to the CPU with a claim / end-of-interrupt handshake over the register bus.
module irq_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Addr_In,
  input  logic              WE,
  input  logic              RE,
  input  logic [31:0]       Data_In,
  output logic [31:0]       Data_Out,
  input  logic [N_SRC-1:0]  irq_src,
  output logic              irq_out,
  output logic [2:0]        irq_id
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  src_dly_q;
  logic [2:0]        id_q, id_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;

  logic [1:0]        reg_sel;
  logic              wr_ctrl, wr_mask, wr_pend, wr_claim, rd_claim;
  logic              claim, eoi;
  logic [N_SRC-1:0]  rises, eligible, id_oh;
  logic [2:0]        winner, next_ptr;
  logic              unused_bits;

  assign unused_bits = ^{Addr_In[1:0], Data_In[31:N_SRC]};

  // Lowest eligible index at or above start, else lowest overall (wrap).
  function automatic logic [2:0] pick(input logic [N_SRC-1:0] elig, input logic [2:0] start);
    logic [2:0] w;
    logic       hit;
    w   = '0;
    hit = 1'b0;
    for (int i = 0; i < N_SRC; i++)
      if (!hit && elig[i] && (3'(i) >= start)) begin
        w   = 3'(i);
        hit = 1'b1;
      end
    for (int i = 0; i < N_SRC; i++)
      if (!hit && elig[i]) begin
        w   = 3'(i);
        hit = 1'b1;
      end
    return w;
  endfunction

  assign reg_sel  = Addr_In[3:2];
  assign wr_ctrl  = WE && (reg_sel == 2'd0);
  assign wr_mask  = WE && (reg_sel == 2'd1);
  assign wr_pend  = WE && (reg_sel == 2'd2);
  assign wr_claim = WE && (reg_sel == 2'd3);
  // A simultaneous write wins over the read side effect.
  assign rd_claim = RE && !WE && (reg_sel == 2'd3);

  assign claim    = rd_claim && (state_q == S_ASSERT);
  assign eoi      = wr_claim && (state_q == S_SERVICE);
  assign rises    = irq_src & ~src_dly_q;
  assign eligible = pend_q & mask_q & {N_SRC{ctrl_q[0]}};
  assign winner   = pick(eligible, ctrl_q[1] ? rr_ptr_q : 3'd0);
  assign next_ptr = (id_q == 3'(N_SRC - 1)) ? 3'd0 : id_q + 3'd1;

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < N_SRC; i++) id_oh[i] = (id_q == 3'(i));
  end

  always_comb begin
    ctrl_d = wr_ctrl ? Data_In[1:0] : ctrl_q;
    mask_d = wr_mask ? Data_In[N_SRC-1:0] : mask_q;
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~Data_In[N_SRC-1:0];
    if (claim)   pend_d = pend_d & ~id_oh;
    // New edges are applied last so a same-cycle set beats any clear.
    pend_d = pend_d | rises;
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d = S_ASSERT;
          id_d    = winner;
        end
      end
      S_ASSERT: begin
        if (claim) begin
          state_d = S_SERVICE;
        end else if (!(|(pend_d & mask_d & id_oh)) || !ctrl_d[0]) begin
          // Withdrawn: drop the request now and re-arbitrate from IDLE.
          state_d = S_IDLE;
          id_d    = 3'd0;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          state_d = S_IDLE;
          id_d    = 3'd0;
          if (ctrl_q[1]) rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = S_IDLE;
        id_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      src_dly_q <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      src_dly_q <= irq_src;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    Data_Out = '0;
    case (reg_sel)
      2'd0: Data_Out[1:0]       = ctrl_q;
      2'd1: Data_Out[N_SRC-1:0] = mask_q;
      2'd2: Data_Out[N_SRC-1:0] = pend_q;
      default: begin
        Data_Out[31]  = (state_q == S_ASSERT);
        Data_Out[2:0] = id_q;
      end
    endcase
  end

  assign irq_out = (state_q == S_ASSERT);
  assign irq_id  = id_q;

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt arbiter between the timer/counter instances (plus other devices) and the CPU's single interrupt input. It latches rising edges of up to `N_SRC` device IRQ lines into a pending register and applies per-source masks. It selects one winner by fixed or round-robin priority. A claim/end-of-interrupt (EOI) handshake runs over the same 4-bit-address register bus the CPU bridge uses for timer access.

## Interface
- `N_SRC`, default 4: number of interrupt sources, legal range 1..8.
- `clk`, in, 1: system clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `Addr_In`, in, 4: register byte offset; only `Addr_In[3:2]` decoded.
- `WE`, in, 1: write strobe, one cycle per write.
- `RE`, in, 1: read strobe; side effects only at offset 0xC.
- `Data_In`, in, 32: write data.
- `Data_Out`, out, 32: combinational read data.
- `irq_src`, in, `N_SRC`: device IRQ levels (e.g. timer `IRQ`), synchronous to `clk`.
- `irq_out`, out, 1: interrupt request to CPU.
- `irq_id`, out, 3: current winner index; valid while state is not IDLE.

## Operation
- Registers:
  - 0x0 CTRL: bit0 EN (global enable), bit1 RR (0 = fixed priority, 1 = round-robin); other bits read 0.
  - 0x4 MASK: bits[N_SRC-1:0], 1 = source enabled.
  - 0x8 PEND: read returns pending bits; a write clears the bits written as 1 (W1C).
  - 0xC CLAIM: read returns bit31 = (state==ASSERT) and bits[2:0] = `irq_id`, all other bits 0. Any write = EOI.
- Unused bits read 0. Reset value of every register is 0.
- Edge capture: `src_d <= irq_src` each cycle. `PEND[i]` is set when `irq_src[i] & ~src_d[i]`. A level held high sets PEND only once.
- Eligible = PEND & MASK, considered only when CTRL.EN = 1.
- Fixed priority: lowest eligible index wins.
- Round-robin: lowest eligible index ≥ `rr_ptr` wins, wrapping to 0. `rr_ptr` (3 bits) is updated to (`irq_id`+1) mod N_SRC on EOI, only when RR=1.
- State machine, state register reset to IDLE:
  - IDLE: when eligible ≠ 0, latch winner into `irq_id` and go to ASSERT.
  - ASSERT: a CLAIM read (`RE` at 0xC) clears `PEND[irq_id]` and goes to SERVICE.
    - Withdrawal: if there is no claim and `PEND[irq_id]`, `MASK[irq_id]` or EN has dropped, go to IDLE; re-arbitration happens from IDLE.
    - `irq_id` is frozen in ASSERT; a higher-priority arrival does not preempt.
  - SERVICE: there is no nesting. New edges still latch into PEND but nothing is asserted. An EOI (`WE` at 0xC) goes to IDLE.
  - EOI outside SERVICE is ignored. A CLAIM read outside ASSERT has no side effect.
- Outputs:
  - `irq_out` = (state==ASSERT), decoded from the state register, glitch-free.
  - `irq_id` resets to 0.
- Simultaneous events:
  - A new edge and a W1C or claim-clear on the same bit in the same cycle: set wins, and the bit stays pending.
  - `WE` and `RE` asserted together: the write executes, and the claim side effect is suppressed.

## Timing
- The source edge is first sampled high at posedge k, so PEND is set at k.
- At k+1 the state moves to ASSERT, and `irq_out` is high after k+1. Latency is 2 clocks.
- CLAIM read at posedge m: `irq_out` is low after m and PEND is cleared at m.
- EOI at posedge e: the state is IDLE after e. If another source is eligible, `irq_out` rises after e+1.
- Async reset mid-operation:
  - All state clears at once and `irq_out` drops without a clock.
  - `src_d` = 0, so any source high at reset release is captured as an edge at the first clock.

## Test plan
- Single source:
  - Setup: MASK=0x1, CTRL=0x1; `irq_src[0]` rises.
  - Expect: `irq_out`=1 two clocks later, and CLAIM reads 0x80000000.
  - Then claim: `irq_out` drops next cycle and PEND=0.
  - Then EOI: state returns to IDLE.
- Fixed priority:
  - Setup: sources 2 and 1 edge in the same cycle, MASK=0xF.
  - Expect: `irq_id`=1.
  - After claim+EOI: `irq_id`=2 asserts and `irq_out` rises 1 clock after EOI.
- Round-robin:
  - Setup: CTRL=0x3, sources 0 and 1 re-edge after every EOI.
  - Expect: claimed ids alternate 0,1,0,1.
- Withdrawal:
  - In ASSERT on id 3, write PEND=0x8.
  - Expect: `irq_out` low next cycle and state IDLE; a CLAIM read then returns 0.
- Level and collision:
  - A level held high for 100 cycles gives exactly one PEND set.
  - An edge in the same cycle as a W1C of that bit leaves PEND set.
- Reset:
  - Assert `reset` asynchronously while in SERVICE.
  - Expect: `irq_out`, all registers and `rr_ptr` are 0 immediately.
  - A source held high across release gives PEND set at the first clock.
